// File: rtl/snake_head_mover_if.sv
// Joystick/control inputs and head-position outputs of the snake head mover.
// The master side is the joystick and game controller; the slave side is the mover.
interface snake_head_mover_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic [1:0]     direction;
    logic           start;
    logic           pause;
    logic           halt;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [1:0]     cur_dir;
    logic           step;
    logic [1:0]     state;

    modport master (
        output direction, start, pause, halt,
        input  head_x, head_y, cur_dir, step, state
    );

    modport slave (
        input  direction, start, pause, halt,
        output head_x, head_y, cur_dir, step, state
    );
endinterface

// File: rtl/snake_head_mover.sv
// Snake head mover: filters joystick turns, advances the head one cell per tick
// with edge wrap-around, and runs the IDLE/RUN/PAUSE/DEAD game state machine.
module snake_head_mover #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int TICK_DIV = 2500000,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic clk,
    input  logic reset,
    snake_head_mover_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DEAD  = 2'b11
    } state_t;

    localparam logic [1:0] D_TOP   = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_DOWN  = 2'b10;
    localparam logic [1:0] D_LEFT  = 2'b11;

    localparam int             CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [X_W-1:0]   r_x, w_x_nxt;
    logic [Y_W-1:0]   r_y, w_y_nxt;
    logic [1:0]       r_cur_dir, w_cur_nxt;
    logic [1:0]       r_next_dir, w_nd_nxt;
    logic             r_step;
    logic             w_move, w_restart;
    logic [1:0]       w_ref_dir;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_cur_nxt   = r_cur_dir;
        w_move      = 1'b0;
        w_restart   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.halt)                w_state_nxt = S_DEAD;
                else if (bus.pause)          w_state_nxt = S_PAUSE;
                else if (r_cnt == CNT_MAX) begin
                    w_move    = 1'b1;
                    w_cnt_nxt = '0;
                end else                     w_cnt_nxt = r_cnt + 1'b1;
            end
            S_PAUSE: begin
                if (bus.halt)        w_state_nxt = S_DEAD;
                else if (!bus.pause) w_state_nxt = S_RUN;
            end
            S_DEAD: begin
                if (bus.start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // On a move edge the pending turn becomes the heading, so the new request
        // is judged against it; this keeps two quick turns from reversing the snake.
        w_ref_dir = w_move ? r_next_dir : r_cur_dir;
        w_nd_nxt  = (bus.direction != (w_ref_dir ^ 2'b10)) ? bus.direction : r_next_dir;

        if (w_move) begin
            w_cur_nxt = r_next_dir;
            case (r_next_dir)
                D_TOP:   w_y_nxt = (r_y == '0)    ? Y_MAX : r_y - 1'b1;
                D_DOWN:  w_y_nxt = (r_y == Y_MAX) ? '0    : r_y + 1'b1;
                D_LEFT:  w_x_nxt = (r_x == '0)    ? X_MAX : r_x - 1'b1;
                default: w_x_nxt = (r_x == X_MAX) ? '0    : r_x + 1'b1;
            endcase
        end

        if (w_restart) begin
            w_x_nxt   = X_START;
            w_y_nxt   = Y_START;
            w_cur_nxt = D_RIGHT;
            w_nd_nxt  = D_RIGHT;
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_x        <= X_START;
            r_y        <= Y_START;
            r_cur_dir  <= D_RIGHT;
            r_next_dir <= D_RIGHT;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_cur_dir  <= w_cur_nxt;
            r_next_dir <= w_nd_nxt;
            r_step     <= w_move;
        end
    end

    assign bus.head_x  = r_x;
    assign bus.head_y  = r_y;
    assign bus.cur_dir = r_cur_dir;
    assign bus.step    = r_step;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_snake_head_mover.sv
// Bench for snake_head_mover on a small 8x6 grid with a 4-cycle move tick.
// A reference model feeds a per-cycle scoreboard; a vector table pins hand-derived results.
module tb_snake_head_mover;
    localparam int GW = 8, GH = 6, XW = 3, YW = 3, TD = 4, SX = 4, SY = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snake_head_mover_if #(.X_W(XW), .Y_W(YW)) bus();

    snake_head_mover #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW),
        .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [1:0]    cur;
        logic          step;
        logic [1:0]    st;
    } out_t;

    typedef struct {
        string      name;
        logic [1:0] d;
        logic       s, p, h;
        int         n;
        out_t       exp;
    } vec_t;

    vec_t tv[$];
    out_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    int m_st, m_cnt, m_x, m_y, m_cur, m_nd, m_step;

    function automatic out_t mk(input int x, y, cur, step, st);
        out_t o;
        o.x = XW'(x); o.y = YW'(y); o.cur = 2'(cur); o.step = 1'(step); o.st = 2'(st);
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.x = bus.head_x; o.y = bus.head_y; o.cur = bus.cur_dir; o.step = bus.step; o.st = bus.state;
        return o;
    endfunction

    function automatic void add(input string nm, input logic [1:0] d, input logic s, p, h,
                                input int n, x, y, cur, step, st);
        tv.push_back('{nm, d, s, p, h, n, mk(x, y, cur, step, st)});
    endfunction

    task automatic check(input string nm, input out_t act, input out_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got x=%0d y=%0d dir=%0d step=%0d st=%0d, want x=%0d y=%0d dir=%0d step=%0d st=%0d",
                     nm, act.x, act.y, act.cur, act.step, act.st, exp.x, exp.y, exp.cur, exp.step, exp.st);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_x = SX; m_y = SY; m_cur = 1; m_nd = 1; m_step = 0;
    endtask

    // Reference model: one clock edge of game behaviour with integer modular moves.
    task automatic m_clock(input logic [1:0] d, input logic s, p, h);
        int ns = m_st;
        bit mv = 0;
        bit rs = 0;
        int refd, newnd;
        case (m_st)
            0: begin m_cnt = 0; if (s) ns = 1; end
            1: if (h) ns = 3;
               else if (p) ns = 2;
               else if (m_cnt == TD - 1) begin mv = 1; m_cnt = 0; end
               else m_cnt++;
            2: if (h) ns = 3; else if (!p) ns = 1;
            default: if (s) begin rs = 1; ns = 1; end
        endcase
        refd  = mv ? m_nd : m_cur;
        newnd = (int'(d) != (refd ^ 2)) ? int'(d) : m_nd;
        if (mv) begin
            m_cur = m_nd;
            case (m_nd)
                0: m_y = (m_y + GH - 1) % GH;
                2: m_y = (m_y + 1) % GH;
                3: m_x = (m_x + GW - 1) % GW;
                default: m_x = (m_x + 1) % GW;
            endcase
        end
        m_nd = newnd;
        if (rs) begin m_x = SX; m_y = SY; m_cur = 1; m_nd = 1; m_cnt = 0; end
        m_st = ns;
        m_step = mv ? 1 : 0;
    endtask

    task automatic cyc(input logic [1:0] d, input logic s, p, h);
        bus.direction = d; bus.start = s; bus.pause = p; bus.halt = h;
        m_clock(d, s, p, h);
        sb_q.push_back(mk(m_x, m_y, m_cur, m_step, m_st));
        @(posedge clk);
        #1;
        check("sb", dut_out(), sb_q.pop_front());
    endtask

    task automatic async_reset(input string nm);
        reset = 1'b1;
        m_reset();
        sb_q.push_back(mk(m_x, m_y, m_cur, m_step, m_st));
        #1;
        check(nm, dut_out(), sb_q.pop_front());
        check({nm, "_const"}, dut_out(), mk(SX, SY, 1, 0, 0));
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // name, dir, start, pause, halt, cycles -> x, y, cur_dir, step, state
        add("start",      2'd1, 1, 0, 0,  1, 4, 3, 1, 0, 1);
        add("right_5",    2'd1, 0, 0, 0,  4, 5, 3, 1, 1, 1);
        add("right_6",    2'd1, 0, 0, 0,  4, 6, 3, 1, 1, 1);
        add("right_7",    2'd1, 0, 0, 0,  4, 7, 3, 1, 1, 1);
        add("x_wrap",     2'd1, 0, 0, 0,  4, 0, 3, 1, 1, 1);
        add("rej_left",   2'd3, 0, 0, 0, 10, 2, 3, 1, 0, 1);
        add("turn_top",   2'd0, 0, 0, 0,  2, 2, 2, 0, 1, 1);
        add("top_1",      2'd0, 0, 0, 0,  4, 2, 1, 0, 1, 1);
        add("top_0",      2'd0, 0, 0, 0,  4, 2, 0, 0, 1, 1);
        add("y_wrap",     2'd0, 0, 0, 0,  4, 2, 5, 0, 1, 1);
        add("back_right", 2'd1, 0, 0, 0,  4, 3, 5, 1, 1, 1);
        add("fast_r",     2'd1, 0, 0, 0,  1, 3, 5, 1, 0, 1);
        add("fast_top",   2'd0, 0, 0, 0,  1, 3, 5, 1, 0, 1);
        add("fast_left",  2'd3, 0, 0, 0,  1, 3, 5, 1, 0, 1);
        add("fast_move",  2'd0, 0, 0, 0,  1, 3, 4, 0, 1, 1);
        add("pre_pause",  2'd0, 0, 0, 0,  2, 3, 4, 0, 0, 1);
        add("paused",     2'd0, 1, 1, 0, 20, 3, 4, 0, 0, 2);
        add("unpause",    2'd0, 0, 0, 0,  1, 3, 4, 0, 0, 1);
        add("resume",     2'd0, 0, 0, 0,  2, 3, 3, 0, 1, 1);
        add("pre_halt",   2'd0, 0, 0, 0,  3, 3, 3, 0, 0, 1);
        add("halt_tc",    2'd0, 0, 0, 1,  1, 3, 3, 0, 0, 3);
        add("dead_hold",  2'd0, 0, 0, 0,  3, 3, 3, 0, 0, 3);
        add("restart",    2'd0, 1, 0, 0,  1, 4, 3, 1, 0, 1);
        add("after_rs",   2'd1, 0, 0, 0,  4, 5, 3, 1, 1, 1);

        reset = 1'b1;
        bus.direction = 2'd1; bus.start = 1'b0; bus.pause = 1'b0; bus.halt = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_out(), mk(SX, SY, 1, 0, 0));
        reset = 1'b0;

        foreach (tv[i]) begin
            for (int k = 0; k < tv[i].n; k++) cyc(tv[i].d, tv[i].s, tv[i].p, tv[i].h);
            check(tv[i].name, dut_out(), tv[i].exp);
        end

        // step is high here; reset must clear it and the head without a clock edge
        async_reset("rst_on_step");
        repeat (5) cyc(2'd1, 1'b0, 1'b0, 1'b0);
        check("idle_wait", dut_out(), mk(SX, SY, 1, 0, 0));
        cyc(2'd1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(2'd1, 1'b0, 1'b0, 1'b0);
        check("cnt3_run", dut_out(), mk(SX, SY, 1, 0, 1));
        async_reset("rst_cnt3");
        repeat (6) cyc(2'd1, 1'b0, 1'b0, 1'b0);
        check("idle_no_start", dut_out(), mk(SX, SY, 1, 0, 0));

        for (int k = 0; k < 400; k++)
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
